// File: rtl/stopwatch_core.sv
// stopwatch_core: centisecond BCD stopwatch (mm:ss.cc) fed by the 10 ms divider toggle.
// Lap hold (frozen display while counting) is built only when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_core #(
    parameter int SYNC_STAGES     = 2,
    parameter bit TICK_BOTH_EDGES = 1'b1
) (
    input  logic       cin,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start_stop_n,
    input  logic       clear_n,
    output logic [3:0] cc_ones,
    output logic [3:0] cc_tens,
    output logic [3:0] s_ones,
    output logic [3:0] s_tens,
    output logic [3:0] m_ones,
    output logic [3:0] m_tens,
    output logic       running,
    output logic       ovf,
    output logic       lap_active
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] tick_sync_q, ss_sync_q, clr_sync_q;
    logic                   tick_edge_q, ss_edge_q, clr_edge_q;
    logic                   tick_s, ss_s, clr_s;
    logic                   tick_evt, start_evt, clr_evt;
    logic [23:0]            cnt_q, cnt_d, shown;
    logic                   ovf_q, ovf_d;
    logic                   cnt_inc, cnt_zero, cnt_we;

    // Increment a packed {m_tens,m_ones,s_tens,s_ones,cc_tens,cc_ones} BCD count; MSB flags wrap.
    function automatic logic [24:0] bcd_inc(input logic [23:0] c);
        logic [23:0] r;
        logic        carry;
        logic [3:0]  dmax;
        r     = c;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dmax = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (r[i*4 +: 4] == dmax) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return {carry, r};
    endfunction

    // Synchronizers and edge registers; keys idle high, tick idles low after reset.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            tick_sync_q <= '0;
            ss_sync_q   <= '1;
            clr_sync_q  <= '1;
            tick_edge_q <= 1'b0;
            ss_edge_q   <= 1'b1;
            clr_edge_q  <= 1'b1;
        end else begin
            tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], tick};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], start_stop_n};
            clr_sync_q  <= {clr_sync_q[SYNC_STAGES-2:0], clear_n};
            tick_edge_q <= tick_s;
            ss_edge_q   <= ss_s;
            clr_edge_q  <= clr_s;
        end
    end

    assign tick_s    = tick_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign clr_s     = clr_sync_q[SYNC_STAGES-1];
    assign tick_evt  = TICK_BOTH_EDGES ? (tick_s ^ tick_edge_q) : (tick_s & ~tick_edge_q);
    assign start_evt = ss_edge_q & ~ss_s;
    // Start wins over a coincident clear.
    assign clr_evt   = clr_edge_q & ~clr_s & ~start_evt;

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_evt) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_evt) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (start_evt)    state_d = ST_RUN;
                else if (clr_evt) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == ST_RUN);
    end

    // Ticks count only in RUN (judged on the current state, so a tick with start in RUN is kept).
    assign cnt_inc  = tick_evt & (state_q == ST_RUN);
    assign cnt_zero = clr_evt & (state_q != ST_RUN);
    assign cnt_we   = cnt_inc | cnt_zero;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (cnt_zero) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (cnt_inc) begin
            {ovf_d, cnt_d} = bcd_inc(cnt_q);
            ovf_d = ovf_d | ovf_q;
        end
    end

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (cnt_we) cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        lap_q, lap_d;
    logic [23:0] disp_q;

    // Any start event leaves RUN or enters it with no hold, so it always drops the hold.
    always_comb begin
        lap_d = lap_q;
        if (start_evt) begin
            lap_d = 1'b0;
        end else if (clr_evt) begin
            lap_d = (state_q == ST_RUN) ? ~lap_q : 1'b0;
        end
    end

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            lap_q <= 1'b0;
        end else begin
            lap_q <= lap_d;
        end
    end

    // Snapshot includes a tick landing on the same cycle as the lap press.
    always_ff @(posedge cin) begin
        if (!lap_q && lap_d) disp_q <= cnt_d;
    end

    assign shown      = lap_q ? disp_q : cnt_q;
    assign lap_active = lap_q;
`else
    assign shown      = cnt_q;
    assign lap_active = 1'b0;
`endif

    assign {m_tens, m_ones, s_tens, s_ones, cc_tens, cc_ones} = shown;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Randomized self-checking bench for stopwatch_core against a centisecond-integer reference model.
// Follows STOPWATCH_LAP_HOLD_EN the same way as the design.
module tb_stopwatch_core;

    logic       cin = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start_stop_n = 1'b1;
    logic       clear_n = 1'b1;
    logic [3:0] cc_ones, cc_tens, s_ones, s_tens, m_ones, m_tens;
    logic       running, ovf, lap_active;
    logic [23:0] dig;

    stopwatch_core dut (
        .cin          (cin),
        .rst_n        (rst_n),
        .tick         (tick),
        .start_stop_n (start_stop_n),
        .clear_n      (clear_n),
        .cc_ones      (cc_ones),
        .cc_tens      (cc_tens),
        .s_ones       (s_ones),
        .s_tens       (s_tens),
        .m_ones       (m_ones),
        .m_tens       (m_tens),
        .running      (running),
        .ovf          (ovf),
        .lap_active   (lap_active)
    );

    assign dig = {m_tens, m_ones, s_tens, s_ones, cc_tens, cc_ones};

    always #10 cin = ~cin;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: state 0=IDLE 1=RUN 2=PAUSE, elapsed time as plain centiseconds.
    int m_state  = 0;
    int m_cs     = 0;
    bit m_ovf    = 1'b0;
    bit m_lap    = 1'b0;
    int m_lap_cs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] cs_to_bcd(input int cs);
        int mm, ss, cc;
        mm = cs / 6000;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_cs    = 0;
        m_ovf   = 1'b0;
        m_lap   = 1'b0;
    endtask

    task automatic model_event(input bit t, input bit s, input bit c);
        if (t && m_state == 1) begin
            m_cs = m_cs + 1;
            if (m_cs == 360000) begin
                m_cs  = 0;
                m_ovf = 1'b1;
            end
        end
        if (s) begin
            if (m_state == 1) begin
                m_state = 2;
                m_lap   = 1'b0;
            end else begin
                m_state = 1;
            end
        end else if (c) begin
            if (m_state == 1) begin
`ifdef STOPWATCH_LAP_HOLD_EN
                if (!m_lap) begin
                    m_lap    = 1'b1;
                    m_lap_cs = m_cs;
                end else begin
                    m_lap = 1'b0;
                end
`endif
            end else begin
                m_cs    = 0;
                m_ovf   = 1'b0;
                m_lap   = 1'b0;
                m_state = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_digits"}, 32'(dig), 32'(cs_to_bcd(m_lap ? m_lap_cs : m_cs)));
        check({tag, "_running"}, 32'(running), 32'(m_state == 1));
        check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
        check({tag, "_lap"}, 32'(lap_active), 32'(m_lap));
    endtask

    task automatic pulse(input bit t, input bit s, input bit c);
        @(negedge cin);
        if (t) tick = ~tick;
        if (s) start_stop_n = 1'b0;
        if (c) clear_n = 1'b0;
        model_event(t, s, c);
        repeat (4) @(negedge cin);
        start_stop_n = 1'b1;
        clear_n      = 1'b1;
        repeat (4) @(negedge cin);
    endtask

    task automatic toggles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge cin);
            tick = ~tick;
            model_event(1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(1, 3)) @(negedge cin);
        end
        repeat (4) @(negedge cin);
    endtask

    task automatic preset(input int cs);
        @(negedge cin);
        force dut.cnt_q = cs_to_bcd(cs);
        @(negedge cin);
        release dut.cnt_q;
        m_cs = cs;
        @(negedge cin);
    endtask

    initial begin
        int op;
        // Reset state
        repeat (3) @(negedge cin);
        check_all("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge cin);

        // Ticks while idle are ignored
        toggles(10);
        check_all("idle_ticks");
        check("idle_const", 32'(dig), 32'h0);

        // Start, then check exact latency on the first tick
        pulse(1'b0, 1'b1, 1'b0);
        check_all("started");
        @(negedge cin);
        tick = ~tick;
        model_event(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge cin);
        check("lat_cycle2", 32'(dig), 32'h0);
        @(negedge cin);
        check("lat_cycle3", 32'(dig), 32'h1);
        repeat (2) @(negedge cin);
        toggles(149);
        check_all("run150");
        check("run150_const", 32'(dig), 32'h000150);

        // Pause and resume
        pulse(1'b0, 1'b1, 1'b0);
        toggles(20);
        check_all("paused");
        check("paused_const", 32'(dig), 32'h000150);
        pulse(1'b0, 1'b1, 1'b0);
        toggles(5);
        check("resume_const", 32'(dig), 32'h000155);
        check_all("resumed");

        // Simultaneous tick+start in RUN then in PAUSE
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check_all("cleared");
        pulse(1'b0, 1'b1, 1'b0);
        toggles(7);
        pulse(1'b1, 1'b1, 1'b0);
        check("sim_run_const", 32'(dig), 32'h000008);
        check("sim_run_paused", 32'(running), 32'd0);
        pulse(1'b1, 1'b1, 1'b0);
        check("sim_pause_const", 32'(dig), 32'h000008);
        check("sim_pause_run", 32'(running), 32'd1);

        // Lap press in RUN at 00:02.00
        toggles(192);
        pulse(1'b0, 1'b0, 1'b1);
        check_all("lap_on");
        toggles(30);
        check_all("lap_held");
        pulse(1'b0, 1'b0, 1'b1);
        check_all("lap_off");
        check("lap_off_const", 32'(dig), 32'h000230);

        // Start and clear together: clear is dropped
        pulse(1'b0, 1'b1, 1'b1);
        check_all("start_clear");

        // Carries and wrap from preset counts (in PAUSE)
        preset(5999);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        check("carry_min", 32'(dig), 32'h010000);
        preset(59999);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        check("carry_10min", 32'(dig), 32'h100000);
        preset(359999);
        pulse(1'b0, 1'b1, 1'b0);
        toggles(1);
        check("wrap_digits", 32'(dig), 32'h0);
        check("wrap_ovf", 32'(ovf), 32'd1);
        toggles(3);
        check_all("after_wrap");
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        check("ovf_cleared", 32'(ovf), 32'd0);
        check_all("wrap_cleared");

        // Randomized mix of ticks, keys and coincident events
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1, 2, 3, 4: toggles(int'($urandom_range(1, 20)));
                5: pulse(1'b0, 1'b1, 1'b0);
                6: pulse(1'b0, 1'b0, 1'b1);
                7: pulse(1'b1, 1'b1, 1'b0);
                8: pulse(1'b1, 1'b0, 1'b1);
                default: pulse(1'($urandom_range(0, 1)), 1'b1, 1'b1);
            endcase
            check_all("rand");
        end

        // Asynchronous reset mid-count
        if (m_state != 1) pulse(1'b0, 1'b1, 1'b0);
        toggles(12);
        @(negedge cin);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge cin);
        rst_n = 1'b1;
        repeat (6) @(negedge cin);
        check_all("post_reset");
        toggles(4);
        check_all("post_reset_ticks");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
